// File: rtl/vect_pkg.sv
// Shared vector-unit types: the decoded arithmetic instruction handed from decode to the lanes.
package vect_pkg;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic       masked;
  } arithm_instr_t;

endpackage

// File: rtl/lane_seq.sv
// Lane sequencer: FIFO of decoded instructions broadcast one at a time to LANES lanes.
// Define LANE_SEQ_WDT_EN to build the WAIT watchdog that sets sticky err_o and forces retirement.
module lane_seq
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int DEPTH      = 4,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       instr_valid_i,
  input  arithm_instr_t              instr_i,
  input  logic [DATA_WIDTH-1:0]      rs1_i,
  output logic                       instr_ready_o,
  output logic                       lane_instr_req_o,
  output logic                       lane_instr_valid_o,
  output arithm_instr_t              lane_instr_o,
  output logic [DATA_WIDTH-1:0]      lane_rs1_o,
  input  logic [LANES-1:0]           lane_ready_i,
  output logic                       done_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state;
  logic [LANES-1:0]      done_mask;
  logic                  req;
  logic                  valid;
  logic                  done;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  arithm_instr_t         instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rs1_mem   [DEPTH];

  logic                  push;
  logic                  pop;
  logic                  all_done;
  logic                  wdt_fire;

  // Full blocks a push even when a pop retires an entry in the same cycle.
  assign push     = instr_valid_i && (count != CW'(DEPTH));
  assign pop      = (state == DONE);
  assign all_done = &(done_mask | lane_ready_i);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_i;
      rs1_mem[wr_ptr]   <= rs1_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= IDLE;
      done_mask <= '0;
      req       <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
    end else begin
      req  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= ISSUE;
            req   <= 1'b1;
            valid <= 1'b1;
          end
        end
        ISSUE: begin
          state     <= WAIT;
          done_mask <= '0;
        end
        WAIT: begin
          done_mask <= done_mask | lane_ready_i;
          if (all_done || wdt_fire) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LANE_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES) + 1;

  logic [WW-1:0] wdt_cnt;
  logic          err;

  assign wdt_fire = (state == WAIT) && !all_done && (wdt_cnt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wdt_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == ISSUE)     wdt_cnt <= '0;
      else if (state == WAIT) wdt_cnt <= wdt_cnt + 1'b1;
      if (wdt_fire) err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
  assign wdt_fire   = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign instr_ready_o      = (count != CW'(DEPTH));
  assign lane_instr_req_o   = req;
  assign lane_instr_valid_o = valid;
  assign done_o             = done;
  assign busy_o             = (state != IDLE) || (count != '0);
  assign count_o            = count;
  // Head stays put until DONE pops it, so lanes may keep reading rs1 during execution.
  assign lane_instr_o       = (count != '0) ? instr_mem[rd_ptr] : '0;
  assign lane_rs1_o         = (count != '0) ? rs1_mem[rd_ptr]   : '0;

endmodule
